// File: rtl/sdram_arbiter_if.sv
// sdram_arbiter_if: SDRAM command-port bundle shared by the controller, processor and display clients.
//  Controller side: o_Ctl_Command/o_Ctl_Address/o_Ctl_Write out, i_Ctl_Read/i_Ctl_Read_Valid/i_Ctl_Write_Done in.
//  Processor side:  i_Proc_Command/i_Proc_Address/i_Proc_Write/i_Proc_SDRAM_Yield in,
//                   o_Proc_Read_Valid/o_Proc_Write_Done/o_Proc_SDRAM_Requested out.
//  Display side:    i_Disp_Req/i_Disp_Command/i_Disp_Address in, o_Disp_Grant/o_Disp_Read_Valid/o_Disp_Read out.
//  Status:          o_Arb_Error out.
//  Directions are named from the arbiter's point of view; master = arbiter, slave = the surrounding clients.
interface sdram_arbiter_if #(parameter int ADDR_W = 22);
  logic [1:0]        o_Ctl_Command;
  logic [ADDR_W-1:0] o_Ctl_Address;
  logic [31:0]       o_Ctl_Write;
  logic [31:0]       i_Ctl_Read;
  logic              i_Ctl_Read_Valid;
  logic              i_Ctl_Write_Done;
  logic [1:0]        i_Proc_Command;
  logic [ADDR_W-1:0] i_Proc_Address;
  logic [31:0]       i_Proc_Write;
  logic              o_Proc_Read_Valid;
  logic              o_Proc_Write_Done;
  logic              o_Proc_SDRAM_Requested;
  logic              i_Proc_SDRAM_Yield;
  logic              i_Disp_Req;
  logic [1:0]        i_Disp_Command;
  logic [ADDR_W-1:0] i_Disp_Address;
  logic              o_Disp_Grant;
  logic              o_Disp_Read_Valid;
  logic [31:0]       o_Disp_Read;
  logic              o_Arb_Error;
  modport master (
    output o_Ctl_Command, o_Ctl_Address, o_Ctl_Write,
    input  i_Ctl_Read, i_Ctl_Read_Valid, i_Ctl_Write_Done,
    input  i_Proc_Command, i_Proc_Address, i_Proc_Write, i_Proc_SDRAM_Yield,
    output o_Proc_Read_Valid, o_Proc_Write_Done, o_Proc_SDRAM_Requested,
    input  i_Disp_Req, i_Disp_Command, i_Disp_Address,
    output o_Disp_Grant, o_Disp_Read_Valid, o_Disp_Read,
    output o_Arb_Error
  );
  modport slave (
    input  o_Ctl_Command, o_Ctl_Address, o_Ctl_Write,
    output i_Ctl_Read, i_Ctl_Read_Valid, i_Ctl_Write_Done,
    output i_Proc_Command, i_Proc_Address, i_Proc_Write, i_Proc_SDRAM_Yield,
    input  o_Proc_Read_Valid, o_Proc_Write_Done, o_Proc_SDRAM_Requested,
    output i_Disp_Req, i_Disp_Command, i_Disp_Address,
    input  o_Disp_Grant, o_Disp_Read_Valid, o_Disp_Read,
    input  o_Arb_Error
  );
endinterface

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: owns the SDRAM controller port, sharing it between the processor (default) and the display (priority).
//  Ports: i_Clk, i_Rst_n (async active-low), bus (sdram_arbiter_if.master: controller, processor and display signals).
//  Optional feature macro SDRAM_ARB_WATCHDOG_EN: yield-timeout watchdog driving sticky o_Arb_Error.
//  Ownership moves only on the processor's yield, so processor bursts are never split; after regaining
//  the port the processor keeps it for PROC_MIN_CYCLES cycles before another display request is forwarded.
module sdram_arbiter #(
  parameter int PROC_MIN_CYCLES = 64
`ifdef SDRAM_ARB_WATCHDOG_EN
  ,parameter int WATCHDOG_CYCLES = 1024
`endif
) (
  input logic i_Clk,
  input logic i_Rst_n,
  sdram_arbiter_if.master bus
);
  localparam logic [1:0] CMD_IDLE = 2'd0;
  localparam logic [1:0] CMD_READ = 2'd1;
  localparam int QW = PROC_MIN_CYCLES > 0 ? $clog2(PROC_MIN_CYCLES + 1) : 1;
  typedef enum logic [1:0] {S_PROC, S_WAIT, S_DISP} state_t;
  state_t state_q, state_d;
  logic [QW-1:0] quant_q, quant_d;
  logic req_q, req_d, grant_q, grant_d;
  logic quant_met, disp_own, disp_release, wd_fire;
  // quant_q holds the remaining quantum; 0 (the reset value) means met. The last counted cycle also
  // counts as met so the processor keeps the port for exactly PROC_MIN_CYCLES cycles in S_PROC.
  assign quant_met = quant_q <= QW'(1);
  assign disp_own = state_q == S_DISP;
  assign disp_release = !bus.i_Disp_Req && bus.i_Disp_Command == CMD_IDLE;
`ifdef SDRAM_ARB_WATCHDOG_EN
  localparam int WW = $clog2(WATCHDOG_CYCLES + 1);
  logic [WW-1:0] wd_q, wd_d;
  logic err_q, err_d;
  // After a timeout the port is taken only once the processor command is idle, so no command is cut.
  assign wd_fire = wd_q == WW'(WATCHDOG_CYCLES) && bus.i_Proc_Command == CMD_IDLE;
  always_comb begin
    wd_d = state_q == S_WAIT && state_d == S_WAIT ? (wd_q == WW'(WATCHDOG_CYCLES) ? wd_q : wd_q + 1'b1) : '0;
    err_d = err_q || (state_q == S_WAIT && wd_q == WW'(WATCHDOG_CYCLES - 1));
  end
  always_ff @(posedge i_Clk or negedge i_Rst_n)
    if (!i_Rst_n) begin
      wd_q <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q <= wd_d;
      err_q <= err_d;
    end
  assign bus.o_Arb_Error = err_q;
`else
  assign wd_fire = 1'b0;
  assign bus.o_Arb_Error = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_PROC: state_d = bus.i_Disp_Req && quant_met ? S_WAIT : S_PROC;
      S_WAIT: state_d = bus.i_Proc_SDRAM_Yield || wd_fire ? S_DISP : S_WAIT;
      S_DISP: state_d = disp_release ? S_PROC : S_DISP;
      default: state_d = S_PROC;
    endcase
    quant_d = state_q == S_DISP && state_d == S_PROC ? QW'(PROC_MIN_CYCLES)
            : state_q == S_PROC && quant_q != '0 ? quant_q - 1'b1 : quant_q;
    // Requested/Grant rise one cycle after the state change but fall on the releasing edge itself.
    req_d = state_q != S_PROC && state_d != S_PROC;
    grant_d = state_q == S_DISP && state_d == S_DISP;
  end
  always_ff @(posedge i_Clk or negedge i_Rst_n)
    if (!i_Rst_n) begin
      state_q <= S_PROC;
      quant_q <= '0;
      req_q <= 1'b0;
      grant_q <= 1'b0;
    end else begin
      state_q <= state_d;
      quant_q <= quant_d;
      req_q <= req_d;
      grant_q <= grant_d;
    end
  // The display may only read; anything else it drives is suppressed to idle.
  assign bus.o_Ctl_Command = !i_Rst_n ? CMD_IDLE
                           : disp_own ? (bus.i_Disp_Command == CMD_READ ? CMD_READ : CMD_IDLE)
                           : bus.i_Proc_Command;
  assign bus.o_Ctl_Address = disp_own ? bus.i_Disp_Address : bus.i_Proc_Address;
  assign bus.o_Ctl_Write = bus.i_Proc_Write;
  assign bus.o_Proc_Read_Valid = !disp_own && bus.i_Ctl_Read_Valid;
  assign bus.o_Proc_Write_Done = !disp_own && bus.i_Ctl_Write_Done;
  assign bus.o_Proc_SDRAM_Requested = req_q;
  assign bus.o_Disp_Grant = grant_q;
  assign bus.o_Disp_Read_Valid = disp_own && bus.i_Ctl_Read_Valid;
  assign bus.o_Disp_Read = bus.i_Ctl_Read;
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed self-checking bench for sdram_arbiter.
module tb_sdram_arbiter;
  localparam logic [1:0] CMD_IDLE = 2'd0;
  localparam logic [1:0] CMD_READ = 2'd1;
  localparam logic [1:0] CMD_WRITE = 2'd2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int n;
  sdram_arbiter_if #(.ADDR_W(22)) bus ();
  sdram_arbiter #(
    .PROC_MIN_CYCLES(64)
`ifdef SDRAM_ARB_WATCHDOG_EN
    ,.WATCHDOG_CYCLES(16)
`endif
  ) dut (
    .i_Clk(clk),
    .i_Rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    bus.i_Ctl_Read = '0;
    bus.i_Ctl_Read_Valid = 1'b0;
    bus.i_Ctl_Write_Done = 1'b0;
    bus.i_Proc_Command = CMD_IDLE;
    bus.i_Proc_Address = '0;
    bus.i_Proc_Write = 32'h0BAD_F00D;
    bus.i_Proc_SDRAM_Yield = 1'b0;
    bus.i_Disp_Req = 1'b0;
    bus.i_Disp_Command = CMD_IDLE;
    bus.i_Disp_Address = '0;
    repeat (2) tick();
    bus.i_Proc_Command = CMD_READ;
    #1;
    chk("rst_cmd_forced_idle", 64'(bus.o_Ctl_Command), 64'(CMD_IDLE));
    chk("rst_requested", 64'(bus.o_Proc_SDRAM_Requested), 64'd0);
    chk("rst_grant", 64'(bus.o_Disp_Grant), 64'd0);
    chk("rst_error", 64'(bus.o_Arb_Error), 64'd0);
    chk("ctl_write_pass", 64'(bus.o_Ctl_Write), 64'h0BAD_F00D);
    bus.i_Proc_Command = CMD_IDLE;
    rst_n = 1'b1;
    tick();
    // Display request with quantum already met: Requested at +2, Grant at +4.
    bus.i_Proc_Address = 22'h2AAA;
    bus.i_Disp_Address = 22'h1000;
    bus.i_Disp_Req = 1'b1;
    tick();
    chk("req_plus1", 64'(bus.o_Proc_SDRAM_Requested), 64'd0);
    chk("addr_in_wait", 64'(bus.o_Ctl_Address), 64'h2AAA);
    tick();
    chk("req_plus2", 64'(bus.o_Proc_SDRAM_Requested), 64'd1);
    chk("grant_plus2", 64'(bus.o_Disp_Grant), 64'd0);
    bus.i_Proc_SDRAM_Yield = 1'b1;
    tick();
    bus.i_Proc_SDRAM_Yield = 1'b0;
    chk("grant_plus3", 64'(bus.o_Disp_Grant), 64'd0);
    chk("disp_addr_mux", 64'(bus.o_Ctl_Address), 64'h1000);
    tick();
    chk("grant_plus4", 64'(bus.o_Disp_Grant), 64'd1);
    bus.i_Disp_Command = CMD_READ;
    bus.i_Ctl_Read = 32'hDEAD_BEEF;
    bus.i_Ctl_Read_Valid = 1'b1;
    #1;
    chk("disp_cmd_read", 64'(bus.o_Ctl_Command), 64'(CMD_READ));
    chk("disp_rv", 64'(bus.o_Disp_Read_Valid), 64'd1);
    chk("proc_rv_gated", 64'(bus.o_Proc_Read_Valid), 64'd0);
    chk("disp_read_data", 64'(bus.o_Disp_Read), 64'hDEAD_BEEF);
    bus.i_Ctl_Read_Valid = 1'b0;
    // Display write attempt is suppressed; processor sees no write completion.
    bus.i_Disp_Command = CMD_WRITE;
    bus.i_Ctl_Write_Done = 1'b1;
    #1;
    chk("disp_write_idle", 64'(bus.o_Ctl_Command), 64'(CMD_IDLE));
    chk("proc_wd_gated", 64'(bus.o_Proc_Write_Done), 64'd0);
    bus.i_Ctl_Write_Done = 1'b0;
    // Release: Grant and Requested drop on the same edge as the state.
    bus.i_Disp_Command = CMD_IDLE;
    bus.i_Disp_Req = 1'b0;
    tick();
    chk("rel_grant", 64'(bus.o_Disp_Grant), 64'd0);
    chk("rel_req", 64'(bus.o_Proc_SDRAM_Requested), 64'd0);
    chk("rel_addr", 64'(bus.o_Ctl_Address), 64'h2AAA);
    // Immediate re-request: Requested stays low for 64 sampled cycles, rises on the 65th edge.
    bus.i_Disp_Req = 1'b1;
    n = 0;
    while (!bus.o_Proc_SDRAM_Requested && n < 200) begin
      tick();
      n++;
    end
    chk("quantum_hold_low", 64'(n - 1), 64'd64);
    bus.i_Proc_SDRAM_Yield = 1'b1;
    tick();
    bus.i_Proc_SDRAM_Yield = 1'b0;
    tick();
    chk("regrant", 64'(bus.o_Disp_Grant), 64'd1);
    bus.i_Disp_Req = 1'b0;
    tick();
    repeat (70) tick();
    // Processor READ burst in flight when the display asks: port stays with the processor.
    bus.i_Proc_Command = CMD_READ;
    bus.i_Proc_Address = 22'h0123;
    bus.i_Disp_Req = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      bus.i_Ctl_Read = 32'(i);
      bus.i_Ctl_Read_Valid = 1'b1;
      #1;
      chk("burst_cmd", 64'(bus.o_Ctl_Command), 64'(CMD_READ));
      chk("burst_addr", 64'(bus.o_Ctl_Address), 64'h0123);
      chk("burst_proc_rv", 64'(bus.o_Proc_Read_Valid), 64'd1);
      chk("burst_disp_rv", 64'(bus.o_Disp_Read_Valid), 64'd0);
    end
    chk("burst_req", 64'(bus.o_Proc_SDRAM_Requested), 64'd1);
    chk("burst_grant", 64'(bus.o_Disp_Grant), 64'd0);
    bus.i_Ctl_Read_Valid = 1'b0;
    bus.i_Proc_Command = CMD_IDLE;
    bus.i_Proc_SDRAM_Yield = 1'b1;
    tick();
    bus.i_Proc_SDRAM_Yield = 1'b0;
    chk("post_burst_addr", 64'(bus.o_Ctl_Address), 64'h1000);
    tick();
    chk("post_burst_grant", 64'(bus.o_Disp_Grant), 64'd1);
    // Reset while the display owns the port.
    bus.i_Disp_Command = CMD_READ;
    rst_n = 1'b0;
    #1;
    chk("midrst_cmd_now", 64'(bus.o_Ctl_Command), 64'(CMD_IDLE));
    tick();
    chk("midrst_grant", 64'(bus.o_Disp_Grant), 64'd0);
    chk("midrst_req", 64'(bus.o_Proc_SDRAM_Requested), 64'd0);
    chk("midrst_cmd", 64'(bus.o_Ctl_Command), 64'(CMD_IDLE));
    bus.i_Disp_Req = 1'b0;
    bus.i_Disp_Command = CMD_IDLE;
    rst_n = 1'b1;
    tick();
    chk("post_rst_error", 64'(bus.o_Arb_Error), 64'd0);
`ifdef SDRAM_ARB_WATCHDOG_EN
    // Processor never yields: error at 16 cycles in S_WAIT, grant only once its command is idle.
    bus.i_Proc_Command = CMD_READ;
    bus.i_Disp_Req = 1'b1;
    tick();
    tick();
    chk("wd_req", 64'(bus.o_Proc_SDRAM_Requested), 64'd1);
    repeat (14) tick();
    chk("wd_err_15", 64'(bus.o_Arb_Error), 64'd0);
    tick();
    chk("wd_err_16", 64'(bus.o_Arb_Error), 64'd1);
    repeat (2) tick();
    chk("wd_hold_busy", 64'(bus.o_Disp_Grant), 64'd0);
    bus.i_Proc_Command = CMD_IDLE;
    tick();
    chk("wd_forced_addr", 64'(bus.o_Ctl_Address), 64'h1000);
    tick();
    chk("wd_grant", 64'(bus.o_Disp_Grant), 64'd1);
    chk("wd_err_sticky", 64'(bus.o_Arb_Error), 64'd1);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
